ets_phase_sequencer: RTL and testbench

Sequences the variable phase-shift port of the ETS clock generator's DCM: accepts a signed target phase offset (in DCM fine-shift steps, relative to the fixed calibration offset), issues one PSEN pulse per step with the correct PSINCDEC, and waits for PSDONE between steps. It tracks the applied offset, handles DCM lock loss and phase-shift overflow, and hands the ETS sweep logic a simple request/done handshake. It runs in the ref_clk domain, the same clock that drives the DCM's PSCLK.

---
 rtl/ets_pkg.sv | 20 ++
 rtl/ets_ps_timeout.sv | 41 ++++
 rtl/ets_phase_sequencer.sv | 160 ++++++++++++++++
 tb/tb_ets_phase_sequencer.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ets_pkg.sv
// Shared types and defaults for the ETS clock-generator phase-shift control.
package ets_pkg;

    localparam int ETS_STEP_W       = 9;
    localparam int ETS_MAX_STEP     = 255;
    localparam int ETS_MIN_STEP     = -255;
    localparam int ETS_DONE_TIMEOUT = 1023;

    // Fixed DCM PHASE_SHIFT attribute; all sequencer offsets are relative to it.
    localparam int ETS_CAL_OFFSET   = 64;

    typedef enum logic [2:0] {
        ST_WAIT_LOCK,
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_DONE,
        ST_ERROR
    } ets_state_e;

endpackage

// File: rtl/ets_ps_timeout.sv
// Loadable up/down cycle counter that flags when the count reaches LIMIT.
module ets_ps_timeout #(
    parameter int LIMIT = 1023,
    parameter int CNT_W = $clog2(LIMIT + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    input  logic             up,
    output logic             expired
);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (load) begin
            count_d = load_val;
        end else if (en) begin
            count_d = up ? count_q + 1'b1 : count_q - 1'b1;
        end
    end

    // Asserted in the cycle whose edge brings the count to LIMIT, so the caller
    // changes state on that same edge.
    assign expired = en && !clr && !load && (count_d == CNT_W'(LIMIT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/ets_phase_sequencer.sv
// Steps the DCM variable phase shift one PSEN at a time towards a clamped signed
// target, tracking the applied offset and handling lock loss, overflow and timeout.
module ets_phase_sequencer
    import ets_pkg::*;
#(
    parameter int STEP_W       = ETS_STEP_W,
    parameter int MAX_STEP     = ETS_MAX_STEP,
    parameter int MIN_STEP     = ETS_MIN_STEP,
    parameter int DONE_TIMEOUT = ETS_DONE_TIMEOUT
) (
    input  logic                     ref_clk,
    input  logic                     reset_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic signed [STEP_W-1:0] req_target,
    output logic                     done,
    output logic                     busy,
    output logic signed [STEP_W-1:0] cur_offset,
    output logic                     error,
    input  logic                     dcm_locked,
    input  logic                     dcm_overflow,
    input  logic                     ps_done,
    output logic                     ps_en,
    output logic                     ps_incdec
);

    localparam logic signed [STEP_W-1:0] MAX_S = STEP_W'(MAX_STEP);
    localparam logic signed [STEP_W-1:0] MIN_S = STEP_W'(MIN_STEP);
    localparam logic signed [STEP_W-1:0] ONE_S = STEP_W'(1);

    ets_state_e               state_q, state_d;
    logic signed [STEP_W-1:0] cur_q, cur_d;
    logic signed [STEP_W-1:0] tgt_q, tgt_d;
    logic signed [STEP_W-1:0] clamped, stepped;
    logic                     incdec_q, incdec_d;
    logic                     done_q, done_d;
    logic                     err_q, err_d;
    logic                     accept;
    logic                     tmo_clr, tmo_en, tmo_expired;

    ets_ps_timeout #(
        .LIMIT(DONE_TIMEOUT)
    ) u_timeout (
        .clk     (ref_clk),
        .rst_n   (reset_n),
        .clr     (tmo_clr),
        .load    (1'b0),
        .load_val('0),
        .en      (tmo_en),
        .up      (1'b1),
        .expired (tmo_expired)
    );

    always_comb begin
        if (req_target > MAX_S) begin
            clamped = MAX_S;
        end else if (req_target < MIN_S) begin
            clamped = MIN_S;
        end else begin
            clamped = req_target;
        end
        stepped = incdec_q ? cur_q + ONE_S : cur_q - ONE_S;
        accept  = req_valid && req_ready;
    end

    always_ff @(posedge ref_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_WAIT_LOCK;
            cur_q    <= '0;
            tgt_q    <= '0;
            incdec_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cur_q    <= cur_d;
            tgt_q    <= tgt_d;
            incdec_q <= incdec_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cur_d    = cur_q;
        tgt_d    = tgt_q;
        incdec_d = incdec_q;
        done_d   = 1'b0;
        err_d    = err_q;

        if (!dcm_locked) begin
            // Lock loss outranks everything; the DCM re-locks at its calibration phase.
            state_d = ST_WAIT_LOCK;
            cur_d   = '0;
        end else begin
            case (state_q)
                ST_WAIT_LOCK: begin
                    cur_d   = '0;
                    state_d = ST_IDLE;
                end
                ST_IDLE, ST_ERROR: begin
                    if (accept) begin
                        tgt_d = clamped;
                        err_d = 1'b0;
                        if (clamped == cur_q) begin
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            incdec_d = (clamped > cur_q);
                            state_d  = ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (dcm_overflow) begin
                        err_d   = 1'b1;
                        state_d = ST_ERROR;
                    end else begin
                        state_d = ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (dcm_overflow) begin
                        err_d   = 1'b1;
                        state_d = ST_ERROR;
                    end else if (ps_done) begin
                        cur_d = stepped;
                        if (stepped == tgt_q) begin
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_ISSUE;
                        end
                    end else if (tmo_expired) begin
                        err_d   = 1'b1;
                        state_d = ST_ERROR;
                    end
                end
                default: begin
                    state_d = ST_WAIT_LOCK;
                    cur_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        req_ready  = dcm_locked && ((state_q == ST_IDLE) || (state_q == ST_ERROR));
        busy       = (state_q == ST_ISSUE) || (state_q == ST_WAIT_DONE);
        ps_en      = (state_q == ST_ISSUE);
        tmo_clr    = (state_q == ST_ISSUE);
        tmo_en     = (state_q == ST_WAIT_DONE);
        ps_incdec  = incdec_q;
        done       = done_q;
        error      = err_q;
        cur_offset = cur_q;
    end

endmodule

// File: tb/tb_ets_phase_sequencer.sv
// Directed bench for ets_phase_sequencer with a behavioural DCM phase-shift port.
module tb_ets_phase_sequencer;

    localparam int W = 10;

    logic                ref_clk = 1'b0;
    logic                reset_n;
    logic                req_valid;
    logic                req_ready;
    logic signed [W-1:0] req_target;
    logic                done;
    logic                busy;
    logic signed [W-1:0] cur_offset;
    logic                error;
    logic                dcm_locked;
    logic                dcm_overflow;
    logic                ps_done = 1'b0;
    logic                ps_en;
    logic                ps_incdec;

    int  n_checks = 0;
    int  n_errors = 0;
    int  cyc = 0;
    int  dly = 0;
    int  en_cnt = 0;
    int  inc_cnt = 0;
    int  done_cnt = 0;
    int  done_cyc = 0;
    bit  dcm_auto = 1'b1;
    logic hold_incdec = 1'b0;
    int  en_cyc[$];
    int  en_cur[$];

    always #5 ref_clk = ~ref_clk;

    ets_phase_sequencer #(
        .STEP_W      (W),
        .MAX_STEP    (255),
        .MIN_STEP    (-255),
        .DONE_TIMEOUT(1023)
    ) dut (
        .ref_clk     (ref_clk),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_target  (req_target),
        .done        (done),
        .busy        (busy),
        .cur_offset  (cur_offset),
        .error       (error),
        .dcm_locked  (dcm_locked),
        .dcm_overflow(dcm_overflow),
        .ps_done     (ps_done),
        .ps_en       (ps_en),
        .ps_incdec   (ps_incdec)
    );

    task automatic check(input string tag, input integer got, input integer exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // DCM model: PSDONE returns 5 cycles after each PSEN while dcm_auto is set.
    always @(negedge ref_clk) begin
        cyc++;
        if (ps_en === 1'b1) check("ps_en_while_waiting", dly, 0);
        if (dly > 0) begin
            check("ps_incdec_stable", ps_incdec, hold_incdec);
            dly--;
            ps_done = (dly == 0);
        end else begin
            ps_done = 1'b0;
        end
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (ps_en === 1'b1) begin
            en_cnt++;
            if (ps_incdec === 1'b1) inc_cnt++;
            en_cyc.push_back(cyc);
            en_cur.push_back(int'(cur_offset));
            hold_incdec = ps_incdec;
            if (dcm_auto) dly = 5;
        end
    end

    task automatic clear_mon();
        @(posedge ref_clk);
        en_cnt   = 0;
        inc_cnt  = 0;
        done_cnt = 0;
        done_cyc = 0;
        en_cyc.delete();
        en_cur.delete();
    endtask

    // Presents a target for one cycle (cycle N) and returns at the negedge of N+1.
    task automatic send_req(input logic signed [W-1:0] t);
        @(negedge ref_clk);
        check("req_ready_before_req", req_ready, 1);
        req_target = t;
        req_valid  = 1'b1;
        @(negedge ref_clk);
        req_valid  = 1'b0;
    endtask

    task automatic wait_done(input int bound, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < bound && !seen; i++) begin
            if (done === 1'b1) seen = 1'b1;
            else @(negedge ref_clk);
        end
    endtask

    task automatic settle();
        repeat (3) @(negedge ref_clk);
    endtask

    initial begin
        bit seen;
        int k;

        reset_n      = 1'b0;
        req_valid    = 1'b0;
        req_target   = '0;
        dcm_locked   = 1'b0;
        dcm_overflow = 1'b0;
        repeat (3) @(negedge ref_clk);
        check("rst_req_ready", req_ready, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_cur_offset", cur_offset, 0);
        check("rst_error", error, 0);
        check("rst_ps_en", ps_en, 0);
        check("rst_ps_incdec", ps_incdec, 0);
        reset_n = 1'b1;
        repeat (3) @(negedge ref_clk);
        check("unlocked_req_ready", req_ready, 0);
        dcm_locked = 1'b1;
        @(negedge ref_clk);
        check("locked_req_ready", req_ready, 1);

        // 0 -> +3: PSEN at P, P+6, P+12; PSDONE at P+17; done at P+18.
        clear_mon();
        send_req(10'sd3);
        check("t1_ps_en_n1", ps_en, 1);
        check("t1_incdec_n1", ps_incdec, 1);
        check("t1_busy", busy, 1);
        wait_done(200, seen);
        check("t1_done_seen", seen, 1);
        settle();
        check("t1_done_cnt", done_cnt, 1);
        check("t1_en_cnt", en_cnt, 3);
        check("t1_inc_cnt", inc_cnt, 3);
        check("t1_cur", cur_offset, 3);
        check("t1_cur_at_en0", en_cur[0], 0);
        check("t1_cur_at_en1", en_cur[1], 1);
        check("t1_cur_at_en2", en_cur[2], 2);
        check("t1_step_gap", en_cyc[1] - en_cyc[0], 6);
        check("t1_done_latency", done_cyc - en_cyc[0], 18);
        check("t1_idle_busy", busy, 0);

        // +3 -> -2: five decrements.
        clear_mon();
        send_req(-10'sd2);
        check("t2_ps_en_n1", ps_en, 1);
        check("t2_incdec_n1", ps_incdec, 0);
        wait_done(200, seen);
        check("t2_done_seen", seen, 1);
        settle();
        check("t2_done_cnt", done_cnt, 1);
        check("t2_en_cnt", en_cnt, 5);
        check("t2_inc_cnt", inc_cnt, 0);
        check("t2_cur", cur_offset, -2);

        clear_mon();
        send_req(10'sd0);
        wait_done(100, seen);
        settle();
        check("t3_cur_zero", cur_offset, 0);
        check("t3_en_cnt_zero", en_cnt, 2);

        // +300 clamps to +255.
        clear_mon();
        send_req(10'sd300);
        wait_done(2000, seen);
        check("t3_done_seen", seen, 1);
        settle();
        check("t3_cur_max", cur_offset, 255);
        check("t3_en_cnt_max", en_cnt, 255);
        check("t3_inc_cnt_max", inc_cnt, 255);
        check("t3_done_cnt_max", done_cnt, 1);

        // Target equal to current: done at N+1, no PSEN.
        clear_mon();
        send_req(10'sd255);
        check("t3_eq_done_n1", done, 1);
        check("t3_eq_ps_en_n1", ps_en, 0);
        settle();
        check("t3_eq_en_cnt", en_cnt, 0);
        check("t3_eq_done_cnt", done_cnt, 1);

        // -300 clamps to -255.
        clear_mon();
        send_req(-10'sd300);
        wait_done(4000, seen);
        check("t3_min_done_seen", seen, 1);
        settle();
        check("t3_cur_min", cur_offset, -255);
        check("t3_en_cnt_min", en_cnt, 510);
        check("t3_inc_cnt_min", inc_cnt, 0);

        // PSDONE withheld: error rises 1023 clock edges after the edge sampling PSEN.
        dcm_auto = 1'b0;
        clear_mon();
        send_req(-10'sd254);
        check("t4_ps_en_n1", ps_en, 1);
        @(posedge ref_clk);
        k = 0;
        while (error !== 1'b1 && k < 1100) begin
            @(posedge ref_clk);
            #1;
            k++;
        end
        check("t4_timeout_edges", k, 1023);
        @(negedge ref_clk);
        check("t4_error", error, 1);
        check("t4_cur_held", cur_offset, -255);
        check("t4_busy", busy, 0);
        check("t4_req_ready", req_ready, 1);
        check("t4_en_cnt", en_cnt, 1);
        dcm_auto = 1'b1;
        clear_mon();
        send_req(-10'sd255);
        check("t4_error_cleared", error, 0);
        check("t4_eq_done_n1", done, 1);

        // Lock drop mid-sweep at +7.
        clear_mon();
        send_req(10'sd20);
        k = 0;
        while (cur_offset !== 10'sd7 && k < 2000) begin
            @(negedge ref_clk);
            k++;
        end
        check("t5_reached_7", cur_offset, 7);
        dcm_locked = 1'b0;
        @(negedge ref_clk);
        check("t5_busy", busy, 0);
        check("t5_cur_zero", cur_offset, 0);
        check("t5_req_ready", req_ready, 0);
        repeat (2) @(negedge ref_clk);
        check("t5_req_ready_unlocked", req_ready, 0);
        dcm_locked = 1'b1;
        repeat (10) @(negedge ref_clk);
        check("t5_cur_after_relock", cur_offset, 0);
        check("t5_no_done", done_cnt, 0);
        check("t5_req_ready_relock", req_ready, 1);

        // Overflow in WAIT_DONE: ERROR, no step, no further PSEN.
        dcm_auto = 1'b0;
        clear_mon();
        send_req(10'sd5);
        check("t6_ps_en_n1", ps_en, 1);
        repeat (2) @(negedge ref_clk);
        dcm_overflow = 1'b1;
        @(negedge ref_clk);
        dcm_overflow = 1'b0;
        check("t6_error", error, 1);
        check("t6_busy", busy, 0);
        check("t6_cur", cur_offset, 0);
        check("t6_req_ready", req_ready, 1);
        repeat (10) @(negedge ref_clk);
        check("t6_en_cnt", en_cnt, 1);
        check("t6_no_done", done_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
